// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and load/store (LS). LS may hold the port for two beats; ties alternate
// round-robin, and a watchdog aborts beats the memory never acknowledges.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | port free; arbitrate between if_req and ls_req
// GNT_IF | fetch beat on the bus, waiting for mem_ack or watchdog
// GNT_LS | load/store beat on the bus; stays until the last beat is done
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        res,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_beats,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_beat_done,
    output logic [31:0] ls_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } state_t;

    // The abort fires on the cycle whose increment would bring wdog to
    // TIMEOUT-1, i.e. the (TIMEOUT-1)th consecutive unacknowledged cycle.
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(TIMEOUT - 2);

    state_t           state;
    logic             last_ls;
    logic [1:0]       beats_left;
    logic [CNT_W-1:0] wdog;
    logic             timeout;
    logic             ls_wins;

    assign if_gnt    = (state == GNT_IF);
    assign ls_gnt    = (state == GNT_LS);
    assign busy      = (state != IDLE);
    assign mem_valid = if_gnt | ls_gnt;
    assign timeout   = mem_valid && !mem_ack && (wdog == WDOG_LIM);

    // The done pulse fires on either completion or abort so the owner
    // never waits forever; err distinguishes the abort.
    assign if_done      = if_gnt && (mem_ack || timeout);
    assign ls_beat_done = ls_gnt && (mem_ack || timeout);
    assign err          = timeout;
    assign if_rdata     = mem_rdata;
    assign ls_rdata     = mem_rdata;

    // On a tie the requester that did not win last time gets the port.
    assign ls_wins = ls_req && (!if_req || !last_ls);

    // Bus mux: owner drives the beat, everything zero while idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_be   = 4'hF;
        end else if (ls_gnt) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
        end
    end

    // Arbitration FSM, beat counter and watchdog.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            last_ls    <= 1'b0;
            beats_left <= 2'd0;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (ls_wins) begin
                        state   <= GNT_LS;
                        last_ls <= 1'b1;
                        case (ls_beats)
                            2'd0:    beats_left <= 2'd1;
                            2'd3:    beats_left <= 2'd2;
                            default: beats_left <= ls_beats;
                        endcase
                    end else if (if_req) begin
                        state   <= GNT_IF;
                        last_ls <= 1'b0;
                    end
                end
                GNT_IF: begin
                    if (mem_ack || timeout) begin
                        state <= IDLE;
                        wdog  <= '0;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                GNT_LS: begin
                    if (mem_ack) begin
                        wdog       <= '0;
                        beats_left <= beats_left - 2'd1;
                        if (beats_left == 2'd1) begin
                            state <= IDLE;
                        end
                    end else if (timeout) begin
                        state      <= IDLE;
                        beats_left <= 2'd0;
                        wdog       <= '0;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    beats_left <= 2'd0;
                    wdog       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        res;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [1:0]  ls_beats;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_beat_done;
    logic [31:0] ls_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err, busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .res(res),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_beats(ls_beats),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_beat_done(ls_beat_done), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_beats = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        res = 1; if_req = 1; ls_req = 1; mem_ack = 1;
        if_addr = 32'h1111_0000; ls_addr = 32'h2222_0000; ls_be = 4'hF;
        @(negedge clk); #1;
        checks++;
        if ({if_gnt, ls_gnt, if_done, ls_beat_done, err, busy, mem_valid, mem_we, mem_be} !== 12'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {if_gnt, ls_gnt, if_done, ls_beat_done, err, busy, mem_valid, mem_we, mem_be});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, ls_rdata});
        end
        idle_inputs();
        @(negedge clk);
        res = 0;
    endtask

    task automatic test_tie();
        @(negedge clk);
        if_req = 1; ls_req = 1; ls_beats = 1; ls_we = 0;
        ls_addr = 32'h40; if_addr = 32'h80; mem_ack = 1; mem_rdata = 32'hA5A5_0001;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tie_sample_busy: got %b expected 0", busy); end
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, if_gnt, ls_beat_done, mem_addr, ls_rdata} !== {3'b101, 32'h40, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL tie_first_ls: got %b %b %b %h %h expected 1 0 1 00000040 a5a50001",
                     ls_gnt, if_gnt, ls_beat_done, mem_addr, ls_rdata);
        end
        @(negedge clk); ls_req = 0; #1;
        checks++;
        if ({busy, if_gnt, ls_gnt} !== 3'b000) begin errors++; $display("FAIL tie_bubble: got %b expected 000", {busy, if_gnt, ls_gnt}); end
        @(negedge clk); #1;
        checks++;
        if ({if_gnt, if_done, mem_addr} !== {2'b11, 32'h80}) begin
            errors++; $display("FAIL tie_then_if: got %b %b %h expected 1 1 00000080", if_gnt, if_done, mem_addr);
        end
        @(negedge clk); if_req = 0; #1;
        @(negedge clk); if_req = 1; ls_req = 1; #1;
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL tie_second_ls: got %b expected 10", {ls_gnt, if_gnt}); end
        @(negedge clk); ls_req = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL tie_second_if: got %b expected 1", if_gnt); end
        @(negedge clk); idle_inputs(); #1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        if_req = 1; if_addr = 32'h100; mem_ack = 0; #1;
        @(negedge clk); #1;
        checks++;
        if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, if_done} !== {2'b10, 32'h100, 4'hF, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_beat: got v=%b we=%b a=%h be=%h wd=%h d=%b expected 1 0 00000100 f 0 0",
                     mem_valid, mem_we, mem_addr, mem_be, mem_wdata, if_done);
        end
        @(negedge clk); mem_ack = 1; mem_rdata = 32'hCAFE_0100; #1;
        checks++;
        if ({if_done, if_rdata, err} !== {1'b1, 32'hCAFE_0100, 1'b0}) begin
            errors++; $display("FAIL fetch_done: got %b %h %b expected 1 cafe0100 0", if_done, if_rdata, err);
        end
        @(negedge clk); if_req = 0; mem_ack = 0; #1;
        checks++;
        if ({busy, if_done, mem_valid} !== 3'b000) begin errors++; $display("FAIL fetch_idle: got %b expected 000", {busy, if_done, mem_valid}); end
    endtask

    task automatic test_split_store();
        @(negedge clk);
        if_req = 1; if_addr = 32'h900; ls_req = 1; ls_we = 1; ls_beats = 2;
        ls_addr = 32'h204; ls_wdata = 32'h1111_2222; ls_be = 4'hC; mem_ack = 1; #1;
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, if_gnt, ls_beat_done, mem_we, mem_addr, mem_wdata, mem_be} !== {4'b1011, 32'h204, 32'h1111_2222, 4'hC}) begin
            errors++;
            $display("FAIL split_beat1: got g=%b ig=%b d=%b we=%b a=%h wd=%h be=%h", ls_gnt, if_gnt, ls_beat_done, mem_we, mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk); ls_addr = 32'h200; ls_wdata = 32'h3333_4444; ls_be = 4'h3; #1;
        checks++;
        if ({ls_gnt, if_gnt, ls_beat_done, mem_addr, mem_wdata, mem_be} !== {3'b101, 32'h200, 32'h3333_4444, 4'h3}) begin
            errors++;
            $display("FAIL split_beat2: got g=%b ig=%b d=%b a=%h wd=%h be=%h", ls_gnt, if_gnt, ls_beat_done, mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk); ls_req = 0; #1;
        checks++;
        if ({busy, if_gnt} !== 2'b00) begin errors++; $display("FAIL split_bubble: got %b expected 00", {busy, if_gnt}); end
        @(negedge clk); #1;
        checks++;
        if ({if_gnt, if_done, mem_addr} !== {2'b11, 32'h900}) begin
            errors++; $display("FAIL split_if_after: got %b %b %h expected 1 1 00000900", if_gnt, if_done, mem_addr);
        end
        @(negedge clk); idle_inputs(); #1;
    endtask

    task automatic test_ls_beats0();
        @(negedge clk);
        ls_req = 1; ls_beats = 0; ls_we = 0; ls_addr = 32'h500; mem_ack = 1; #1;
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, ls_beat_done} !== 2'b11) begin errors++; $display("FAIL beats0_done: got %b expected 11", {ls_gnt, ls_beat_done}); end
        @(negedge clk); ls_req = 0; #1;
        checks++;
        if ({busy, ls_beat_done} !== 2'b00) begin errors++; $display("FAIL beats0_single: got %b expected 00", {busy, ls_beat_done}); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL beats0_stay_idle: got %b expected 0", busy); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ls_req = 1; ls_beats = 2; ls_addr = 32'h600; mem_ack = 0; #1;
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({mem_valid, ls_gnt, err, ls_beat_done} !== {2'b11, (k == TIMEOUT - 1) ? 2'b11 : 2'b00}) begin
                errors++;
                $display("FAIL timeout_cycle%0d: got v=%b g=%b err=%b d=%b", k, mem_valid, ls_gnt, err, ls_beat_done);
            end
        end
        @(negedge clk); ls_req = 0; #1;
        checks++;
        if ({busy, err, ls_beat_done} !== 3'b000) begin errors++; $display("FAIL timeout_idle: got %b expected 000", {busy, err, ls_beat_done}); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_abandon: got %b expected 0", busy); end
        idle_inputs();
    endtask

    task automatic test_timeout_ack();
        @(negedge clk);
        if_req = 1; if_addr = 32'h700; mem_ack = 0; #1;
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            @(negedge clk);
            mem_ack = (k == TIMEOUT - 1); mem_rdata = 32'h7700 + k; #1;
            checks++;
            if ({if_gnt, err, if_done} !== {2'b10, (k == TIMEOUT - 1)}) begin
                errors++; $display("FAIL tmo_ack_cycle%0d: got g=%b err=%b d=%b", k, if_gnt, err, if_done);
            end
        end
        @(negedge clk); if_req = 0; mem_ack = 0; #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tmo_ack_idle: got %b expected 0", busy); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        ls_req = 1; ls_beats = 2; ls_addr = 32'h300; ls_be = 4'hF; mem_ack = 0; #1;
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, mem_valid} !== 2'b11) begin errors++; $display("FAIL arst_pre: got %b expected 11", {ls_gnt, mem_valid}); end
        #2; res = 1; mem_ack = 1; #1;
        checks++;
        if ({ls_gnt, if_gnt, mem_valid, busy, ls_beat_done, err, mem_be} !== 10'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL arst_immediate: got g=%b v=%b b=%b d=%b a=%h", ls_gnt, mem_valid, busy, ls_beat_done, mem_addr);
        end
        @(negedge clk); ls_req = 0; mem_ack = 0; res = 0; #1;
        @(negedge clk); if_req = 1; ls_req = 1; ls_beats = 1; mem_ack = 1; #1;
        @(negedge clk); #1;
        checks++;
        if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL arst_tie_ls: got %b expected 10", {ls_gnt, if_gnt}); end
        @(negedge clk); ls_req = 0; #1;
        @(negedge clk); #1;
        @(negedge clk); idle_inputs(); #1;
    endtask

    task automatic test_random();
        int  owner, left, waited;
        bit  last_ls, drop_if, drop_ls, stall, to;
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [5:0]  e_ctrl;
        owner = 0; left = 0; waited = 0;
        last_ls = 0; drop_if = 0; drop_ls = 0; stall = 0;
        @(negedge clk); idle_inputs(); res = 1;
        @(negedge clk); res = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (drop_if) if_req = 0;
            if (drop_ls) ls_req = 0;
            drop_if = 0; drop_ls = 0;
            if (!if_req && $urandom_range(9) < 3) begin if_req = 1; if_addr = $urandom; end
            if (!ls_req && $urandom_range(9) < 3) begin ls_req = 1; ls_we = 1'($urandom_range(1)); end
            if (owner != 2) ls_beats = 2'($urandom_range(3));
            ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'($urandom_range(15));
            if (owner == 0) stall = ($urandom_range(9) == 0);
            mem_ack = !stall && ($urandom_range(3) != 0);
            mem_rdata = $urandom;
            #1;
            to      = (owner != 0) && !mem_ack && (waited == TIMEOUT - 2);
            e_we    = (owner == 2) ? ls_we : 1'b0;
            e_addr  = (owner == 1) ? if_addr : (owner == 2) ? ls_addr : 32'h0;
            e_wdata = (owner == 2) ? ls_wdata : 32'h0;
            e_be    = (owner == 1) ? 4'hF : (owner == 2) ? ls_be : 4'h0;
            e_ctrl  = {owner == 1, owner == 2, (owner == 1) && (mem_ack || to),
                       (owner == 2) && (mem_ack || to), to, owner != 0};
            checks++;
            if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be} !== {owner != 0, e_we, e_addr, e_wdata, e_be}) begin
                errors++;
                $display("FAIL rand_bus cyc%0d: got v=%b we=%b a=%h wd=%h be=%h expected v=%b we=%b a=%h wd=%h be=%h",
                         cyc, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, owner != 0, e_we, e_addr, e_wdata, e_be);
            end
            checks++;
            if ({if_gnt, ls_gnt, if_done, ls_beat_done, err, busy} !== e_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl cyc%0d: got %b expected %b",
                         cyc, {if_gnt, ls_gnt, if_done, ls_beat_done, err, busy}, e_ctrl);
            end
            checks++;
            if ({if_rdata, ls_rdata} !== {mem_rdata, mem_rdata}) begin
                errors++; $display("FAIL rand_rdata cyc%0d: got %h %h expected %h", cyc, if_rdata, ls_rdata, mem_rdata);
            end
            if (owner == 0) begin
                waited = 0;
                if (ls_req && (!if_req || !last_ls)) begin
                    owner = 2; last_ls = 1;
                    left = (ls_beats == 0) ? 1 : (ls_beats == 3) ? 2 : int'(ls_beats);
                end else if (if_req) begin
                    owner = 1; last_ls = 0;
                end
            end else if (mem_ack || to) begin
                waited = 0;
                if (owner == 1) begin
                    owner = 0; drop_if = 1;
                end else begin
                    left = to ? 0 : left - 1;
                    if (left == 0) begin owner = 0; drop_ls = 1; end
                end
            end else begin
                waited++;
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        res = 1;
        test_reset();
        test_tie();
        test_single_fetch();
        test_split_store();
        test_ls_beats0();
        test_timeout();
        test_timeout_ack();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
